// File: rtl/udiv_q_arb.sv
// rtl/udiv_q_arb.sv - round-robin arbiter sharing one divider among N channels, in-order tag return
// Optional per-channel completion counters: UDIV_ARB_CNT_EN.
module udiv_q_arb #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int QI = 16,
  parameter int QF = 8,
  parameter int FD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req_valid,
  output logic [N-1:0]             req_ready,
  input  logic [N*DW-1:0]          req_dividend,
  input  logic [N*DW-1:0]          req_divisor,
  output logic                     div_s_valid,
  input  logic                     div_s_ready,
  output logic [DW-1:0]            div_s_dividend,
  output logic [DW-1:0]            div_s_divisor,
  input  logic                     div_m_valid,
  output logic                     div_m_ready,
  input  logic                     div_m_dz,
  input  logic [QI-1:0]            div_m_q_int,
  input  logic [QF-1:0]            div_m_q_frac,
  input  logic [DW-1:0]            div_m_rem,
  output logic [N-1:0]             rsp_valid,
  input  logic [N-1:0]             rsp_ready,
  output logic                     rsp_dz,
  output logic [QI-1:0]            rsp_q_int,
  output logic [QF-1:0]            rsp_q_frac,
  output logic [DW-1:0]            rsp_rem,
  output logic [$clog2(FD+1)-1:0]  inflight,
`ifdef UDIV_ARB_CNT_EN
  output logic [N*16-1:0]          done_cnt,
`endif
  output logic                     err_orphan
);

  localparam int NW = $clog2(N);
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int CW = $clog2(FD+1);

  logic [NW-1:0] ptr, gnt_q, grant, head;
  logic          lock, gnt_vld;
  logic [NW-1:0] tag_mem [FD];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty, push, pop;
  int            idx;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FD-1)) ? '0 : p + PW'(1);
  endfunction

  // Reverse scan so the last hit is the first valid channel at or after ptr.
  always_comb begin
    grant   = gnt_q;
    gnt_vld = lock;
    idx     = 0;
    if (!lock) begin
      grant = '0;
      for (int k = N-1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % N;
        if (req_valid[idx]) begin
          grant   = NW'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  assign fifo_full      = (count == CW'(FD));
  assign fifo_empty     = (count == '0);
  assign div_s_valid    = gnt_vld && !fifo_full;
  assign push           = div_s_valid && div_s_ready;
  assign div_s_dividend = req_dividend[int'(grant)*DW +: DW];
  assign div_s_divisor  = req_divisor[int'(grant)*DW +: DW];
  assign head           = tag_mem[rd_ptr];

  always_comb begin
    req_ready = '0;
    if (push) req_ready[grant] = 1'b1;
  end

  // An empty FIFO swallows results so a stray divider output cannot stall it.
  always_comb begin
    rsp_valid   = '0;
    div_m_ready = 1'b1;
    if (!fifo_empty) begin
      rsp_valid[head] = div_m_valid;
      div_m_ready     = rsp_ready[head];
    end
  end

  assign pop        = !fifo_empty && div_m_valid && div_m_ready;
  assign rsp_dz     = div_m_dz;
  assign rsp_q_int  = div_m_q_int;
  assign rsp_q_frac = div_m_q_frac;
  assign rsp_rem    = div_m_rem;
  assign inflight   = count;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      lock       <= 1'b0;
      gnt_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= nxt(wr_ptr);
        ptr    <= (grant == NW'(N-1)) ? '0 : grant + NW'(1);
        lock   <= 1'b0;
      end else if (div_s_valid) begin
        lock  <= 1'b1;
        gnt_q <= grant;
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (fifo_empty && div_m_valid) err_orphan <= 1'b1;
    end
  end

`ifdef UDIV_ARB_CNT_EN
  logic [15:0] cnt [N];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) cnt[i] <= '0;
      else if (rsp_valid[i] && rsp_ready[i]) cnt[i] <= cnt[i] + 16'd1;
    end
  end

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < N; i++) done_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule
